// File: rtl/dm_arbiter_pkg.sv
// Shared definitions for the data-memory arbiter: access selector codes and arbiter states.
package dm_arbiter_pkg;

    localparam logic [3:0] SEL_NONE = 4'd0;
    localparam logic [3:0] SEL_LB   = 4'd1;
    localparam logic [3:0] SEL_LBU  = 4'd2;
    localparam logic [3:0] SEL_LH   = 4'd3;
    localparam logic [3:0] SEL_LHU  = 4'd4;
    localparam logic [3:0] SEL_LW   = 4'd5;
    localparam logic [3:0] SEL_SB   = 4'd6;
    localparam logic [3:0] SEL_SH   = 4'd7;
    localparam logic [3:0] SEL_SW   = 4'd8;

    typedef enum logic {
        ARB_OWN_CPU  = 1'b0,
        ARB_DMA_SLOT = 1'b1
    } arb_state_t;

    // DMA may only touch word-aligned addresses inside the 16 KiB data memory.
    function automatic logic dma_addr_ok(input logic [31:0] addr);
        return (addr[31:14] == 18'd0) && (addr[1:0] == 2'b00);
    endfunction

endpackage

// File: rtl/dm_arbiter_fsm.sv
// Ownership FSM for the DM port: CPU by default, a DMA slot when the CPU is idle
// or after the DMA has waited STARVE_LIMIT CPU-served cycles.
module dm_arb_fsm
    import dm_arbiter_pkg::*;
#(
    parameter int STARVE_LIMIT = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       cpu_req,
    input  logic       dma_req,
    output arb_state_t state
);

    localparam logic [3:0] LAST_CPU_CYCLE = 4'(STARVE_LIMIT - 1);

    logic [3:0] cnt;

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= ARB_OWN_CPU;
            cnt   <= 4'd0;
        end else begin
            case (state)
                ARB_OWN_CPU: begin
                    if (!dma_req) begin
                        cnt <= 4'd0;
                    end else if (!cpu_req || cnt == LAST_CPU_CYCLE) begin
                        state <= ARB_DMA_SLOT;
                        cnt   <= 4'd0;
                    end else begin
                        cnt <= cnt + 4'd1;
                    end
                end
                ARB_DMA_SLOT: begin
                    state <= ARB_OWN_CPU;
                    cnt   <= 4'd0;
                end
                default: begin
                    state <= ARB_OWN_CPU;
                    cnt   <= 4'd0;
                end
            endcase
        end
    end

endmodule

// File: rtl/dm_arbiter.sv
// Shares the single DM port between the M stage and a word-wide DMA/debug requester.
// Optional DMA address checking is compiled in with DM_ARB_ADDRCHK_EN.
module dm_arbiter
    import dm_arbiter_pkg::*;
#(
    parameter int          STARVE_LIMIT = 4,
    parameter logic [31:0] DMA_PC       = 32'hFFFF_FFFC
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        cpu_req,
    input  logic        cpu_we,
    input  logic [3:0]  cpu_sel,
    input  logic [31:0] cpu_addr,
    input  logic [31:0] cpu_wdata,
    input  logic [31:0] cpu_pc,
    output logic [31:0] cpu_rdata,
    output logic        cpu_stall,
    input  logic        dma_req,
    input  logic        dma_we,
    input  logic [31:0] dma_addr,
    input  logic [31:0] dma_wdata,
    output logic        dma_ack,
    output logic [31:0] dma_rdata,
    output logic        dma_err,
    output logic        dm_we,
    output logic [3:0]  dm_sel,
    output logic [31:0] dm_addr,
    output logic [31:0] dm_wdata,
    output logic [31:0] dm_pc,
    input  logic [31:0] dm_rdata
);

    arb_state_t state;
    logic       dma_slot;
    logic       dma_bad;

    dm_arb_fsm #(
        .STARVE_LIMIT(STARVE_LIMIT)
    ) u_fsm (
        .clk    (clk),
        .reset  (reset),
        .cpu_req(cpu_req),
        .dma_req(dma_req),
        .state  (state)
    );

    assign dma_slot = (state == ARB_DMA_SLOT);

`ifdef DM_ARB_ADDRCHK_EN
    assign dma_bad = ~dma_addr_ok(dma_addr);
`else
    logic unused_dma_addr_bits;
    assign dma_bad              = 1'b0;
    assign unused_dma_addr_bits = ^{dma_addr[31:14], dma_addr[1:0]};
`endif

    // Writes are blocked during reset so a slot cut short never commits.
    always_comb begin
        if (dma_slot) begin
            dm_we    = dma_we & ~dma_bad & ~reset;
            dm_sel   = dma_we ? SEL_SW : SEL_LW;
            dm_addr  = {18'd0, dma_addr[13:2], 2'b00};
            dm_wdata = dma_wdata;
            dm_pc    = DMA_PC;
        end else begin
            dm_we    = cpu_req & cpu_we & ~reset;
            dm_sel   = cpu_sel;
            dm_addr  = cpu_addr;
            dm_wdata = cpu_wdata;
            dm_pc    = cpu_pc;
        end
    end

    assign dma_ack   = dma_slot & ~reset;
    assign dma_err   = dma_ack & dma_bad;
    assign dma_rdata = (dma_slot && !dma_bad) ? dm_rdata : 32'h0;
    assign cpu_rdata = dm_rdata;
    assign cpu_stall = dma_slot & cpu_req & ~reset;

endmodule
